// File: rtl/acc_requant_drain.sv
// acc_requant_drain
//    Requantizes final MAC accumulator values into signed N-bit activations.
//    Each accepted beat passes three registered stages (bias add, rounding
//    arithmetic shift, ReLU + saturation) and then enters a first-word-
//    fall-through output FIFO. Upstream flow control is credit based: the
//    credit counter covers every beat in the stages plus the FIFO, so an
//    accepted beat always has a FIFO slot waiting for it.
//
//    Build option: define ACC_DRAIN_SAT_CNT_EN to include the saturation
//    counter; without it sat_count is tied to zero.
//
//    Ports
//       clk        rising-edge clock
//       rst        synchronous active-high reset (flushes pipeline and FIFO)
//       acc_valid  acc_in carries a final MAC result
//       acc_in     signed accumulator value (SUM_WIDTH)
//       acc_ready  a beat can be accepted this cycle (registered)
//       cfg_bias   signed bias, sampled with the beat
//       cfg_shift  rounding right-shift amount, sampled with the beat
//       cfg_relu   clamp negatives to zero, sampled with the beat
//       out_valid  out_data holds a result
//       out_data   signed N-bit requantized activation
//       out_ready  downstream accepts out_data
//       sat_count  number of saturated results, sticks at 16'hFFFF
module acc_requant_drain #(
   parameter int N         = 8,
   parameter int SUM_WIDTH = (N * 2) + 4,
   parameter int DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        acc_valid,
   input  logic signed [SUM_WIDTH-1:0] acc_in,
   output logic                        acc_ready,
   input  logic signed [SUM_WIDTH-1:0] cfg_bias,
   input  logic        [4:0]           cfg_shift,
   input  logic                        cfg_relu,
   output logic                        out_valid,
   output logic signed [N-1:0]         out_data,
   input  logic                        out_ready,
   output logic        [15:0]          sat_count
);

   localparam int S1W = SUM_WIDTH + 1;
   localparam int S2W = SUM_WIDTH + 2;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;

   localparam logic signed [S2W-1:0] MAXV = S2W'(2 ** (N - 1) - 1);
   localparam logic signed [S2W-1:0] MINV = S2W'(-(2 ** (N - 1)));

   logic                  accept;
   logic                  pop;

   logic                  v1, v2, v3;
   logic signed [S1W-1:0] s1_q;
   logic        [4:0]     sh1;
   logic                  relu1, relu2;
   logic signed [S2W-1:0] s2_q;
   logic        [N-1:0]   d3;

   logic signed [S1W-1:0] s1_c;
   logic        [4:0]     sh_c;
   logic signed [S2W-1:0] s1x, rnd, s2_c;
   logic signed [S2W-1:0] v_relu;
   logic        [N-1:0]   d3_c;

   logic        [N-1:0]   mem [DEPTH];
   logic        [AW-1:0]  wr_ptr, rd_ptr;
   logic        [CW-1:0]  count;
   logic        [CW-1:0]  credit, credit_nx;
   logic                  ready_q;

   assign acc_ready = ready_q;
   assign accept    = acc_valid && ready_q;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign credit_nx = credit + CW'(accept) - CW'(pop);

   always_comb begin
      s1_c = S1W'(acc_in) + S1W'(cfg_bias);
      // Shift amounts beyond the accumulator width saturate to the widest legal shift.
      sh_c = (int'(cfg_shift) > SUM_WIDTH - 1) ? 5'(SUM_WIDTH - 1) : cfg_shift;

      // Half-LSB rounding constant; (1 << sh) >> 1 is zero for sh = 0.
      s1x  = S2W'(s1_q);
      rnd  = (S2W'(1) << sh1) >> 1;
      s2_c = (s1x + rnd) >>> sh1;

      // ReLU first, so a clamped negative never reports as saturated.
      v_relu = (relu2 && (s2_q < 0)) ? '0 : s2_q;
      if (v_relu > MAXV)
         d3_c = MAXV[N-1:0];
      else if (v_relu < MINV)
         d3_c = MINV[N-1:0];
      else
         d3_c = v_relu[N-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         credit  <= '0;
         ready_q <= 1'b0;
      end else begin
         v1 <= accept;
         if (accept) begin
            s1_q  <= s1_c;
            sh1   <= sh_c;
            relu1 <= cfg_relu;
         end
         v2 <= v1;
         if (v1) begin
            s2_q  <= s2_c;
            relu2 <= relu1;
         end
         v3 <= v2;
         if (v2)
            d3 <= d3_c;
         if (v3) begin
            mem[wr_ptr] <= d3;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count   <= count + CW'(v3) - CW'(pop);
         credit  <= credit_nx;
         ready_q <= (credit_nx < CW'(DEPTH));
      end
   end

`ifdef ACC_DRAIN_SAT_CNT_EN
   logic sat_c;
   logic sat3;

   assign sat_c = (v_relu > MAXV) || (v_relu < MINV);

   always_ff @(posedge clk) begin
      if (rst) begin
         sat3      <= 1'b0;
         sat_count <= '0;
      end else begin
         if (v2)
            sat3 <= sat_c;
         // Counted when the result lands in the FIFO.
         if (v3 && sat3 && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
      end
   end
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_acc_requant_drain.sv
// Scoreboard bench for acc_requant_drain (N=8, SUM_WIDTH=20, DEPTH=4).
// The stimulus side pushes hand-computed results as beats are accepted;
// a negedge monitor pops and compares whenever the DUT presents data.
module tb_acc_requant_drain;

   localparam int N  = 8;
   localparam int SW = 20;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 acc_valid = 1'b0;
   logic signed [SW-1:0] acc_in = '0;
   logic                 acc_ready;
   logic signed [SW-1:0] cfg_bias = '0;
   logic        [4:0]    cfg_shift = '0;
   logic                 cfg_relu = 1'b0;
   logic                 out_valid;
   logic signed [N-1:0]  out_data;
   logic                 out_ready = 1'b0;
   logic        [15:0]   sat_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_sat  = 0;
   logic signed [N-1:0] exp_q[$];

   acc_requant_drain #(.N(N), .SUM_WIDTH(SW), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .acc_valid (acc_valid),
      .acc_in    (acc_in),
      .acc_ready (acc_ready),
      .cfg_bias  (cfg_bias),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat_exp();
`ifdef ACC_DRAIN_SAT_CNT_EN
      return exp_sat;
`else
      return 0;
`endif
   endfunction

   // Monitor: pop on transfer, otherwise the held head must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", longint'(out_data), -999);
         end else if (out_ready) begin
            check("out_data", longint'(out_data), longint'(exp_q.pop_front()));
         end else begin
            check("held_data", longint'(out_data), longint'(exp_q[0]));
         end
      end
   end

   task automatic send(input int acc, input int bias, input int shift, input bit relu,
                       input int exp, input bit sat);
      int waited;
      @(negedge clk);
      acc_valid = 1'b1;
      acc_in    = SW'(acc);
      cfg_bias  = SW'(bias);
      cfg_shift = 5'(shift);
      cfg_relu  = relu;
      waited = 0;
      while (!acc_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!acc_ready) begin
         check("accept_timeout", 0, 1);
      end else begin
         exp_q.push_back(N'(exp));
         if (sat) exp_sat++;
      end
      @(posedge clk);
      #1 acc_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("drain_timeout", cyc < 100, 1);
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      int acc; int bias; int shift; bit relu; int exp; bit sat;
   } vec_t;

   vec_t vecs[15] = '{
      '{1000,    24, 3,  1'b0,  127, 1'b1},
      '{-300,    0,  2,  1'b0,  -75, 1'b0},
      '{-300,    0,  2,  1'b1,  0,   1'b0},
      '{-500000, 0,  0,  1'b0, -128, 1'b1},
      '{5,       0,  1,  1'b0,  3,   1'b0},
      '{-5,      0,  1,  1'b0, -2,   1'b0},
      '{127,     0,  0,  1'b0,  127, 1'b0},
      '{128,     0,  0,  1'b0,  127, 1'b1},
      '{-128,    0,  0,  1'b0, -128, 1'b0},
      '{-129,    0,  0,  1'b0, -128, 1'b1},
      '{262144,  0,  31, 1'b0,  1,   1'b0},
      '{262144,  0,  19, 1'b0,  1,   1'b0},
      '{200,   -100, 0,  1'b1,  100, 1'b0},
      '{50,    -100, 0,  1'b1,  0,   1'b0},
      '{-1000,   0,  0,  1'b1,  0,   1'b0}
   };

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int accepted;
      int nxt;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_acc_ready", acc_ready, 0);
      check("rst_sat_count", sat_count, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", acc_ready, 1);
      out_ready = 1'b1;

      // Latency: accepted at edge k, visible after edge k+3
      send(100, -5, 0, 1'b0, 95, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("latency_edge_%0d", i), out_valid, (i == 3) ? 1 : 0);
      end
      check("sat_after_95", sat_count, 0);
      drain();

      // Directed vectors, issued back to back with changing configuration
      foreach (vecs[i])
         send(vecs[i].acc, vecs[i].bias, vecs[i].shift, vecs[i].relu, vecs[i].exp, vecs[i].sat);
      drain();
      check("sat_count_vectors", sat_count, sat_exp());

      // Backpressure: only DEPTH beats get in while the output is stalled
      out_ready = 1'b0;
      accepted = 0;
      nxt = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc_valid = 1'b1;
         acc_in    = SW'(nxt);
         cfg_bias  = '0;
         cfg_shift = '0;
         cfg_relu  = 1'b0;
         if (acc_ready) begin
            exp_q.push_back(N'(nxt));
            accepted++;
            nxt++;
         end
      end
      @(negedge clk);
      acc_valid = 1'b0;
      check("stall_accepted", accepted, 4);
      check("stall_acc_ready", acc_ready, 0);
      check("stall_out_data", longint'(out_data), 1);
      out_ready = 1'b1;
      send(5, 0, 0, 1'b0, 5, 1'b0);
      send(6, 0, 0, 1'b0, 6, 1'b0);
      drain();

      // Mid-stream reset with two beats in flight
      send(10, 0, 0, 1'b0, 10, 1'b0);
      send(20, 0, 0, 1'b0, 20, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      exp_sat = 0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_acc_ready", acc_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_next", acc_ready, 1);
      check("mid_rst_sat_count", sat_count, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_no_output", out_valid, 0);
      end

      // Still functional after reset
      send(42, 1, 1, 1'b0, 22, 1'b0);
      drain();
      check("final_sat_count", sat_count, sat_exp());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
